// File: rtl/rpsc_trip_annunciator.sv
// rpsc_trip_annunciator
// Operator annunciator for the trip flip-flop card LA lines. It provides
// ringback lamp sequencing per channel, a common horn and first-out capture.
// Every output is a register decoded from FSM, phase and first-out state.
module rpsc_trip_annunciator #(
  parameter int N_CH       = 8,
  parameter int DB_CYCLES  = 50000,
  parameter int FLASH_HALF = 5000000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] trip_la,
  input  logic            ack_pb,
  input  logic            rst_pb,
  input  logic            test_pb,
  output logic [N_CH-1:0] lamp,
  output logic            horn,
  output logic [N_CH-1:0] first_out,
  output logic            alarm_any
);

  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_ALERT    = 2'd1;
  localparam logic [1:0] ST_ACKED    = 2'd2;
  localparam logic [1:0] ST_RINGBACK = 2'd3;

  localparam int DBW   = $clog2(DB_CYCLES + 1);
  localparam int FW    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int NSYNC = N_CH + 3;

  // Synchronizer bundle layout: [N_CH-1:0] LA lines, then ack, rst, test.
  logic [NSYNC-1:0]         sync1_q;
  logic [NSYNC-1:0]         sync2_q;
  logic [N_CH-1:0]          s_in_q;

  // Debounce state, one slot per pushbutton: 0 = ack, 1 = rst, 2 = test.
  logic [2:0]               pb_acc_q;
  logic [1:0]               pb_prev_q;
  logic [2:0][DBW-1:0]      db_cnt_q;
  logic                     ack_p_q;
  logic                     rst_p_q;
  logic                     test_lvl;

  logic [FW-1:0]            flash_cnt_q;
  logic [1:0]               fast_tog_q;
  logic                     fast_q;
  logic                     slow_q;

  logic [N_CH-1:0][1:0]     st_q;
  logic [N_CH-1:0][1:0]     st_d;
  logic [N_CH-1:0]          fo_q;
  logic [N_CH-1:0]          fo_d;
  logic [N_CH-1:0]          entry;
  logic                     all_norm_d;
  logic                     rst_eff;

  logic [N_CH-1:0]          lamp_d;
  logic                     horn_d;
  logic                     any_d;
  logic [N_CH-1:0]          lamp_q;
  logic                     horn_q;
  logic [N_CH-1:0]          first_out_q;
  logic                     alarm_any_q;

  assign test_lvl = pb_acc_q[2];
  // A coincident acknowledge wins; the reset press is dropped for that cycle.
  assign rst_eff  = rst_p_q & ~ack_p_q;

  // Two-flop synchronizers, plus one retiming stage that feeds the channel FSMs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      s_in_q  <= '0;
    end else begin
      sync1_q <= {test_pb, rst_pb, ack_pb, trip_la};
      sync2_q <= sync1_q;
      s_in_q  <= sync2_q[N_CH-1:0];
    end
  end

  // Pushbutton debounce: accept a new level after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pb_acc_q  <= '0;
      pb_prev_q <= '0;
      db_cnt_q  <= '0;
      ack_p_q   <= 1'b0;
      rst_p_q   <= 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (sync2_q[N_CH+b] == pb_acc_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DBW'(DB_CYCLES - 1)) begin
          pb_acc_q[b] <= sync2_q[N_CH+b];
          db_cnt_q[b] <= '0;
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + DBW'(1);
        end
      end
      pb_prev_q <= pb_acc_q[1:0];
      ack_p_q   <= pb_acc_q[0] & ~pb_prev_q[0];
      rst_p_q   <= pb_acc_q[1] & ~pb_prev_q[1];
    end
  end

  // Free-running flash generator: fast toggles on each wrap, slow on every fourth fast toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt_q <= '0;
      fast_tog_q  <= '0;
      fast_q      <= 1'b0;
      slow_q      <= 1'b0;
    end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
      flash_cnt_q <= '0;
      fast_q      <= ~fast_q;
      fast_tog_q  <= fast_tog_q + 2'd1;
      if (fast_tog_q == 2'd3) begin
        slow_q <= ~slow_q;
      end
    end else begin
      flash_cnt_q <= flash_cnt_q + FW'(1);
    end
  end

  // Channel ringback FSMs and first-out capture (next state)
  always_comb begin
    st_d       = st_q;
    entry      = '0;
    all_norm_d = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      case (st_q[i])
        ST_NORMAL: begin
          if (s_in_q[i]) begin
            st_d[i] = ST_ALERT;
          end
        end
        ST_ALERT: begin
          // Locked in: only an acknowledge moves the channel on.
          if (ack_p_q) begin
            st_d[i] = s_in_q[i] ? ST_ACKED : ST_RINGBACK;
          end
        end
        ST_ACKED: begin
          if (!s_in_q[i]) begin
            st_d[i] = ST_RINGBACK;
          end
        end
        default: begin
          if (s_in_q[i]) begin
            st_d[i] = ST_ALERT;
          end else if (rst_eff) begin
            st_d[i] = ST_NORMAL;
          end
        end
      endcase
      entry[i] = (st_q[i] == ST_NORMAL) && (st_d[i] == ST_ALERT);
      if (st_d[i] != ST_NORMAL) begin
        all_norm_d = 1'b0;
      end
    end
    if (rst_eff && all_norm_d) begin
      fo_d = '0;
    end else if (fo_q == '0) begin
      fo_d = entry;
    end else begin
      fo_d = fo_q;
    end
  end

  // Channel state and first-out registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= '0;
      fo_q <= '0;
    end else begin
      st_q <= st_d;
      fo_q <= fo_d;
    end
  end

  // Lamp, horn and summary decode from the current state and flash phases
  always_comb begin
    lamp_d = '0;
    horn_d = 1'b0;
    any_d  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      case (st_q[i])
        ST_NORMAL: lamp_d[i] = 1'b0;
        ST_ALERT:  lamp_d[i] = fast_q;
        ST_ACKED:  lamp_d[i] = 1'b1;
        default:   lamp_d[i] = slow_q;
      endcase
      if (st_q[i] == ST_ALERT) begin
        horn_d = 1'b1;
      end
      if (st_q[i] != ST_NORMAL) begin
        any_d = 1'b1;
      end
    end
    if (test_lvl) begin
      lamp_d = '1;
    end
  end

  // Registered panel outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lamp_q      <= '0;
      horn_q      <= 1'b0;
      first_out_q <= '0;
      alarm_any_q <= 1'b0;
    end else begin
      lamp_q      <= lamp_d;
      horn_q      <= horn_d;
      first_out_q <= fo_q;
      alarm_any_q <= any_d;
    end
  end

  assign lamp      = lamp_q;
  assign horn      = horn_q;
  assign first_out = first_out_q;
  assign alarm_any = alarm_any_q;

endmodule
